// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder with fixed wait states
// Define DMEM_RANGE_CHECK_EN to add the addr_err output and out-of-range suppression.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enM,
    input  logic        memwriteM,
    input  logic [3:0]  sig_write,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        longest_stall,
    output logic [31:0] readdataM,
`ifdef DMEM_RANGE_CHECK_EN
    output logic        addr_err,
`endif
    output logic        d_stall
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   index_q;
    logic                    write_q;
    logic [3:0]              strobe_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    access;
    logic                    suppress;
    logic [31:0]             mem [DEPTH];

    // Low address bits are ignored by design; upper bits only matter for the range check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^aluoutM;

`ifdef DMEM_RANGE_CHECK_EN
    logic out_of_range_q;
    assign suppress = out_of_range_q;
`else
    assign suppress = 1'b0;
`endif

    assign readdataM = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        d_stall    = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                d_stall = mem_enM;
                if (mem_enM) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                d_stall = 1'b1;
                if (wait_cnt == 4'd0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!longest_stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            index_q  <= '0;
            write_q  <= 1'b0;
            strobe_q <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
`ifdef DMEM_RANGE_CHECK_EN
            out_of_range_q <= 1'b0;
            addr_err       <= 1'b0;
`endif
        end else begin
            if (state == IDLE && mem_enM) begin
                index_q  <= aluoutM[ADDR_WIDTH+1:2];
                write_q  <= memwriteM;
                strobe_q <= sig_write;
                wdata_q  <= writedataM;
                wait_cnt <= 4'(WAIT_CYCLES);
`ifdef DMEM_RANGE_CHECK_EN
                out_of_range_q <= (aluoutM >> (ADDR_WIDTH + 2)) != 32'd0;
`endif
            end
            if (state == BUSY && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (access && !write_q) begin
                rdata_q <= suppress ? 32'd0 : mem[index_q];
            end
`ifdef DMEM_RANGE_CHECK_EN
            if (access) begin
                addr_err <= out_of_range_q;
            end else if (state == DONE && state_next == IDLE) begin
                addr_err <= 1'b0;
            end
`endif
        end
    end

    // Array is deliberately left out of reset; a reset on the access edge blocks the write.
    always_ff @(posedge clk) begin
        if (access && write_q && !suppress && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe_q[i]) begin
                    mem[index_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule
